// File: rtl/writeback_stage.sv
// writeback_stage
//
// Merges ALU and load/store results onto the register file's single write port.
// ALU results go straight to the registered write outputs; load results are
// queued in a small FIFO so a stalled load never holds up the ALU. The FIFO head
// gets priority only when the FIFO is full. Writes to x0 are accepted but never
// strobed, since the register file does not protect x0.
//
// Optional build macro:
//   WB_LSU_BYPASS_EN - a load accepted while the FIFO is empty and no ALU result
//                      is accepted in the same cycle skips the FIFO and is
//                      written with 1-cycle latency.
//
// Ports:
//   clock, reset_n                      clock, async active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data ALU result handshake and payload
//   lsu_valid/lsu_ready/lsu_rd/lsu_data load result handshake and payload
//   write_register/write_data/write_enable registered register-file write port
//   lsu_count                           load FIFO occupancy
//   busy                                FIFO non-empty or a write in flight

module writeback_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned LSU_DEPTH  = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_WIDTH-1:0]        alu_rd,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  input  logic                         lsu_valid,
  output logic                         lsu_ready,
  input  logic [ADDR_WIDTH-1:0]        lsu_rd,
  input  logic [DATA_WIDTH-1:0]        lsu_data,
  output logic [ADDR_WIDTH-1:0]        write_register,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic                         write_enable,
  output logic [$clog2(LSU_DEPTH):0]   lsu_count,
  output logic                         busy
);

  localparam int unsigned PtrW = $clog2(LSU_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CountFull = CntW'(LSU_DEPTH);

  logic [ADDR_WIDTH-1:0] rd_mem   [LSU_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [LSU_DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;

  logic full, empty;
  logic alu_hs, lsu_hs;
  logic bypass, push, pop;

  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);

  // Readiness is gated by reset so nothing is accepted while reset is held.
  assign alu_ready = reset_n & ~full;
  assign lsu_ready = reset_n & ~full;

  assign alu_hs = alu_valid & alu_ready;
  assign lsu_hs = lsu_valid & lsu_ready;

`ifdef WB_LSU_BYPASS_EN
  assign bypass = lsu_hs & empty & ~alu_hs;
`else
  assign bypass = 1'b0;
`endif

  assign push = lsu_hs & ~bypass;
  // When full, alu_ready is low so alu_hs is 0 and the head always drains.
  assign pop  = ~empty & ~alu_hs;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    if (alu_hs) begin
      wreg_d  = alu_rd;
      wdata_d = alu_data;
      we_d    = (alu_rd != '0);
    end else if (pop) begin
      wreg_d  = rd_mem[rd_ptr_q];
      wdata_d = data_mem[rd_ptr_q];
      we_d    = (rd_mem[rd_ptr_q] != '0);
    end else if (bypass) begin
      wreg_d  = lsu_rd;
      wdata_d = lsu_data;
      we_d    = (lsu_rd != '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= lsu_rd;
      data_mem[wr_ptr_q] <= lsu_data;
    end
  end

  assign write_register = wreg_q;
  assign write_data     = wdata_q;
  assign write_enable   = we_q;
  assign lsu_count      = count_q;
  assign busy           = ~empty | we_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clock;
  logic        reset_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        write_enable;
  logic [2:0]  lsu_count;
  logic        busy;

  int n_checks;
  int n_errs;

  writeback_stage #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .LSU_DEPTH (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .write_register(write_register),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .lsu_count     (lsu_count),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_write(input string tag, input logic we, input logic [4:0] rd,
                             input logic [31:0] data);
    check_eq({tag, ".we"}, 64'(write_enable), 64'(we));
    if (we) begin
      check_eq({tag, ".rd"}, 64'(write_register), 64'(rd));
      check_eq({tag, ".data"}, 64'(write_data), 64'(data));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errs    = 0;
    reset_n   = 1'b0;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_rd    = '0;
    lsu_data  = '0;

    // Reset state
    repeat (3) step();
    check_eq("rst.alu_ready", 64'(alu_ready), 64'd0);
    check_eq("rst.lsu_ready", 64'(lsu_ready), 64'd0);
    check_eq("rst.we", 64'(write_enable), 64'd0);
    check_eq("rst.reg", 64'(write_register), 64'd0);
    check_eq("rst.data", 64'(write_data), 64'd0);
    check_eq("rst.count", 64'(lsu_count), 64'd0);
    check_eq("rst.busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    #1;
    check_eq("rel.alu_ready", 64'(alu_ready), 64'd1);
    check_eq("rel.lsu_ready", 64'(lsu_ready), 64'd1);

    // Single ALU write, 1-cycle latency, one-cycle strobe
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    check_write("alu1", 1'b1, 5'd5, 32'hDEADBEEF);
    check_eq("alu1.busy", 64'(busy), 64'd1);
    step();
    check_eq("alu1.we_drop", 64'(write_enable), 64'd0);
    check_eq("alu1.busy_drop", 64'(busy), 64'd0);

    // Simultaneous ALU and load: ALU first, load queued even with bypass
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check_write("sim.first", 1'b1, 5'd1, 32'h11);
    check_eq("sim.count1", 64'(lsu_count), 64'd1);
    step();
    check_write("sim.second", 1'b1, 5'd2, 32'h22);
    check_eq("sim.count0", 64'(lsu_count), 64'd0);
    step();
    check_eq("sim.idle", 64'(write_enable), 64'd0);

    // ALU held busy while four loads fill the FIFO
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(8 + i); lsu_data = 32'h100 + 32'(i);
      step();
      check_write("fill.alu", 1'b1, 5'd3, 32'h33);
      check_eq("fill.count", 64'(lsu_count), 64'(i + 1));
    end
    lsu_valid = 1'b0;
    check_eq("full.alu_ready", 64'(alu_ready), 64'd0);
    check_eq("full.lsu_ready", 64'(lsu_ready), 64'd0);
    step();
    check_write("full.head", 1'b1, 5'd8, 32'h100);
    check_eq("full.count3", 64'(lsu_count), 64'd3);
    check_eq("full.alu_ready_back", 64'(alu_ready), 64'd1);
    check_eq("full.lsu_ready_back", 64'(lsu_ready), 64'd1);
    step();
    check_write("full.alu_again", 1'b1, 5'd3, 32'h33);
    check_eq("full.count_hold", 64'(lsu_count), 64'd3);
    alu_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      check_write("drain", 1'b1, 5'(8 + i), 32'h100 + 32'(i));
      check_eq("drain.count", 64'(lsu_count), 64'(3 - i));
    end
    step();
    check_eq("drain.idle_we", 64'(write_enable), 64'd0);
    check_eq("drain.idle_busy", 64'(busy), 64'd0);

    // Write to x0 is consumed but never strobed
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    #1;
    check_eq("x0.ready", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 1'b0;
    check_eq("x0.we", 64'(write_enable), 64'd0);
    check_eq("x0.busy", 64'(busy), 64'd0);
    step();
    check_eq("x0.we2", 64'(write_enable), 64'd0);

    // Reset pulsed mid-stream drops everything immediately
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hC0;
    step();
    lsu_rd = 5'd13; lsu_data = 32'hD0;
    step();
    lsu_rd = 5'd14; lsu_data = 32'hE0;
    reset_n = 1'b0;
    #1;
    check_eq("mrst.count", 64'(lsu_count), 64'd0);
    check_eq("mrst.we", 64'(write_enable), 64'd0);
    check_eq("mrst.busy", 64'(busy), 64'd0);
    check_eq("mrst.lsu_ready", 64'(lsu_ready), 64'd0);
    step();
    check_eq("mrst.we_hold", 64'(write_enable), 64'd0);
    lsu_valid = 1'b0;
    reset_n   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("mrst.post_we", 64'(write_enable), 64'd0);
      check_eq("mrst.post_count", 64'(lsu_count), 64'd0);
    end

    // Single load latency
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    step();
    lsu_valid = 1'b0;
`ifdef WB_LSU_BYPASS_EN
    check_write("ld.bypass", 1'b1, 5'd7, 32'h77);
    check_eq("ld.count", 64'(lsu_count), 64'd0);
`else
    check_eq("ld.we_early", 64'(write_enable), 64'd0);
    check_eq("ld.count", 64'(lsu_count), 64'd1);
    step();
    check_write("ld.fifo", 1'b1, 5'd7, 32'h77);
    check_eq("ld.count0", 64'(lsu_count), 64'd0);
`endif
    step();
    check_eq("ld.idle", 64'(write_enable), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Writeback stage that merges results from the ALU and the load/store unit onto the register file's single write port, and drives its `write_register` / `write_data` / `write_enable` inputs. Load results are buffered in a small FIFO so a blocked load never stalls the ALU path. Writes to x0 are discarded here, because the register file does not protect x0.

## Interface
- `DATA_WIDTH`, 32, width of the result data.
- `ADDR_WIDTH`, 5, width of the register index.
- `LSU_DEPTH`, 4, number of entries in the load-result FIFO; a power of two, at least 2.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result valid.
- `alu_ready` out 1: stage accepts the ALU result.
- `alu_rd` in ADDR_WIDTH: ALU destination register.
- `alu_data` in DATA_WIDTH: ALU result.
- `lsu_valid` in 1: load result valid.
- `lsu_ready` out 1: stage accepts the load result.
- `lsu_rd` in ADDR_WIDTH: load destination register.
- `lsu_data` in DATA_WIDTH: load result.
- `write_register` out ADDR_WIDTH: register file write index (registered).
- `write_data` out DATA_WIDTH: register file write data (registered).
- `write_enable` out 1: register file write strobe (registered).
- `lsu_count` out clog2(LSU_DEPTH)+1: current FIFO occupancy.
- `busy` out 1: high when the FIFO is non-empty or `write_enable` is high.

## Operation
- A handshake occurs when valid and ready are both high at a rising edge. The source must hold its payload stable while valid is high and ready is low.
- At most one register write is issued per cycle.
- Selection is made each cycle. The state is FULL when `lsu_count == LSU_DEPTH`, otherwise NORMAL.
  - NORMAL: ALU has priority. `alu_ready=1`. The FIFO head is popped only in a cycle with no ALU handshake.
  - FULL: the FIFO head has priority. `alu_ready=0`, the head is popped, and the stage returns to NORMAL next cycle.
- `lsu_ready = (lsu_count != LSU_DEPTH)`. A pop in the same cycle does not raise `lsu_ready` while the FIFO is full.
- Push and pop in the same cycle: `lsu_count` is unchanged, and ordering is preserved because the pushed entry goes behind the head.
- Pointers wrap modulo LSU_DEPTH. `lsu_count` is tracked separately so that full and empty can be told apart.
- Writes with rd == 0 are accepted and consume their slot as normal, but `write_enable` stays 0 for them.
- While `reset_n` is low: `alu_ready=0`, `lsu_ready=0`, and the FIFO is emptied.
- Reset asserted mid-operation drops all buffered entries and any pending write immediately. No write may be emitted during reset.
- Reset values: `write_register=0`, `write_data=0`, `write_enable=0`, `lsu_count=0`, `busy=0`.

## Timing
- ALU path: handshake at edge k. The write outputs are valid in the cycle after edge k, and the register file captures at edge k+1. Latency is 1 cycle.
- LSU path, with an empty FIFO and no ALU traffic: push at edge k, pop at edge k+1, register file captures at edge k+2. Latency is 2 cycles.
- `write_enable` is high for exactly one cycle per issued write. Back-to-back writes keep it high continuously.
- After `reset_n` deasserts, the ready outputs go high combinationally; the first handshake can occur at the next rising edge.

## Configuration
- `WB_LSU_BYPASS_EN` defined:
  - A load handshake that occurs with the FIFO empty and no ALU handshake in the same cycle bypasses the FIFO.
  - It is written directly to the output registers, giving a latency of 1 cycle (same as ALU), and `lsu_count` stays 0.
- `WB_LSU_BYPASS_EN` undefined: every load passes through the FIFO, with a minimum latency of 2 cycles.

## Test plan
- Reset with `reset_n=0`, then release: all outputs 0, and `alu_ready=lsu_ready=1` after release. A single ALU write (rd=5, data=0xDEADBEEF) produces `write_enable=1`, `write_register=5`, `write_data=0xDEADBEEF` for exactly one cycle, one cycle after the handshake.
- Simultaneous ALU write (rd=1, 0x11) and LSU write (rd=2, 0x22) with an empty FIFO: rd=1 is written first, then rd=2 on the next cycle. With `WB_LSU_BYPASS_EN` defined, the load must still queue because the ALU handshake takes priority.
- `alu_valid` held high continuously while 4 loads are pushed (LSU_DEPTH=4):
  - `lsu_count` reaches 4, then `alu_ready=0` and `lsu_ready=0`.
  - The head is written, `lsu_count` drops to 3, and `alu_ready` returns to 1.
  - All loads are eventually written, in push order.
- ALU write with rd=0 and data=0xFFFFFFFF: handshake completes, `write_enable` stays 0, `busy` stays 0.
- Three loads are pushed with no ALU traffic and `reset_n` is pulsed low at the edge after the second push: no further `write_enable`, `lsu_count=0` immediately, and the FIFO stays empty after release.
- Single load (rd=7, 0x77) with the FIFO empty and no ALU traffic: the write appears 2 cycles after the handshake without `WB_LSU_BYPASS_EN`, and 1 cycle after with it.
